// File: rtl/basic_block_window_pkg.sv
// Shared instruction and FSM definitions for the regex basic-block execution unit.
package basic_block_window_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int INSTR_WIDTH  = 16;
  localparam int OPCODE_MSB   = INSTR_WIDTH - 1;
  localparam int OPCODE_LSB   = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int DATA_MSB     = OPCODE_LSB - 1;
  localparam int DATA_LSB     = 0;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ACCEPT                = 3'd0,
    OP_SPLIT                 = 3'd1,
    OP_MATCH                 = 3'd2,
    OP_JMP                   = 3'd3,
    OP_END_WITHOUT_ACCEPTING = 3'd4,
    OP_MATCH_ANY             = 3'd5,
    OP_ACCEPT_PARTIAL        = 3'd6,
    OP_NOT_MATCH             = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_OUT1  = 3'd3,
    ST_OUT2  = 3'd4
  } state_e;

endpackage

// File: rtl/basic_block_window_decode.sv
// Combinational instruction decode: decides what a thread does with its current character.
module basic_block_window_decode
  import basic_block_window_pkg::*;
#(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8,
  parameter int MEMORY_WIDTH    = 16,
  parameter int CC_ID_BITS      = 2
) (
  input  logic [MEMORY_WIDTH-1:0]    instruction,
  input  logic [CHARACTER_WIDTH-1:0] ch,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [CC_ID_BITS-1:0]      cc_id,
  output logic                       produce,
  output logic                       is_split,
  output logic                       accept,
  output logic [PC_WIDTH-1:0]        next_pc,
  output logic [CC_ID_BITS-1:0]      next_cc_id,
  output logic [PC_WIDTH-1:0]        split_target
);

  localparam int DATA_WIDTH = MEMORY_WIDTH - OPCODE_WIDTH;

  opcode_e                       opcode;
  logic [DATA_WIDTH-1:0]         data;
  logic [PC_WIDTH-1:0]           pc_inc;
  logic [CC_ID_BITS-1:0]         cc_inc;
  logic                          char_eq;
  logic                          unused_data;

  assign opcode      = opcode_e'(instruction[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data        = instruction[DATA_WIDTH-1:0];
  assign pc_inc      = pc + PC_WIDTH'(1);
  assign cc_inc      = cc_id + CC_ID_BITS'(1);
  assign char_eq     = (ch == data[CHARACTER_WIDTH-1:0]);
  assign unused_data = ^data;

  // Per-opcode outcome; the slot counter wraps deliberately at the end of the window.
  always_comb begin
    produce      = 1'b0;
    is_split     = 1'b0;
    accept       = 1'b0;
    next_pc      = pc_inc;
    next_cc_id   = cc_id;
    split_target = data[PC_WIDTH-1:0];
    case (opcode)
      OP_ACCEPT:         accept = (ch == '0);
      OP_SPLIT: begin
        produce  = 1'b1;
        is_split = 1'b1;
      end
      OP_MATCH: begin
        produce    = char_eq;
        next_cc_id = cc_inc;
      end
      OP_JMP: begin
        produce = 1'b1;
        next_pc = data[PC_WIDTH-1:0];
      end
      OP_END_WITHOUT_ACCEPTING: produce = 1'b0;
      OP_MATCH_ANY: begin
        produce    = 1'b1;
        next_cc_id = cc_inc;
      end
      OP_ACCEPT_PARTIAL: accept = 1'b1;
      OP_NOT_MATCH: begin
        produce    = !char_eq;
        next_cc_id = cc_inc;
      end
      default: produce = 1'b0;
    endcase
  end

endmodule

// File: rtl/basic_block_window.sv
// Regex execution unit: fetches one thread's instruction, executes it, emits up to two threads.
module basic_block_window
  import basic_block_window_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CC_ID_BITS        = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [(CHARACTER_WIDTH<<CC_ID_BITS)-1:0] current_characters,
  input  logic                                     input_pc_valid,
  output logic                                     input_pc_ready,
  input  logic [PC_WIDTH-1:0]                      input_pc,
  input  logic [CC_ID_BITS-1:0]                    input_cc_id,
  output logic                                     memory_valid,
  input  logic                                     memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]             memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                  memory_data,
  output logic                                     output_pc_valid,
  input  logic                                     output_pc_ready,
  output logic [PC_WIDTH-1:0]                      output_pc,
  output logic [CC_ID_BITS-1:0]                    output_cc_id,
  output logic                                     output_pc_is_directed_to_current,
  output logic                                     accepts
);

  state_e                      state;
  logic [PC_WIDTH-1:0]         pc_q;
  logic [CC_ID_BITS-1:0]       cc_q;
  logic                        split_pending;
  logic [PC_WIDTH-1:0]         split_target_q;
  logic [CHARACTER_WIDTH-1:0]  ch;

  logic                        dec_produce;
  logic                        dec_is_split;
  logic                        dec_accept;
  logic [PC_WIDTH-1:0]         dec_next_pc;
  logic [CC_ID_BITS-1:0]       dec_next_cc_id;
  logic [PC_WIDTH-1:0]         dec_split_target;

  assign ch = current_characters[cc_q*CHARACTER_WIDTH +: CHARACTER_WIDTH];

  basic_block_window_decode #(
    .PC_WIDTH        (PC_WIDTH),
    .CHARACTER_WIDTH (CHARACTER_WIDTH),
    .MEMORY_WIDTH    (MEMORY_WIDTH),
    .CC_ID_BITS      (CC_ID_BITS)
  ) u_decode (
    .instruction  (memory_data),
    .ch           (ch),
    .pc           (pc_q),
    .cc_id        (cc_q),
    .produce      (dec_produce),
    .is_split     (dec_is_split),
    .accept       (dec_accept),
    .next_pc      (dec_next_pc),
    .next_cc_id   (dec_next_cc_id),
    .split_target (dec_split_target)
  );

  // Thread FSM with every handshake output registered so the neighbours see glitch-free signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                            <= ST_IDLE;
      pc_q                             <= '0;
      cc_q                             <= '0;
      split_pending                    <= 1'b0;
      split_target_q                   <= '0;
      input_pc_ready                   <= 1'b1;
      memory_valid                     <= 1'b0;
      memory_addr                      <= '0;
      output_pc_valid                  <= 1'b0;
      output_pc                        <= '0;
      output_cc_id                     <= '0;
      output_pc_is_directed_to_current <= 1'b0;
      accepts                          <= 1'b0;
    end else begin
      accepts <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (input_pc_valid && input_pc_ready) begin
            pc_q           <= input_pc;
            cc_q           <= input_cc_id;
            input_pc_ready <= 1'b0;
            memory_valid   <= 1'b1;
            memory_addr    <= MEMORY_ADDR_WIDTH'(input_pc);
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (memory_ready) begin
            memory_valid <= 1'b0;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          accepts <= dec_accept;
          if (dec_produce) begin
            output_pc_valid                  <= 1'b1;
            output_pc                        <= dec_next_pc;
            output_cc_id                     <= dec_next_cc_id;
            output_pc_is_directed_to_current <= (dec_next_cc_id == cc_q);
            split_pending                    <= dec_is_split;
            split_target_q                   <= dec_split_target;
            state                            <= ST_OUT1;
          end else begin
            input_pc_ready <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        ST_OUT1: begin
          if (output_pc_ready) begin
            if (split_pending) begin
              split_pending                    <= 1'b0;
              output_pc                        <= split_target_q;
              output_cc_id                     <= cc_q;
              output_pc_is_directed_to_current <= 1'b1;
              state                            <= ST_OUT2;
            end else begin
              output_pc_valid <= 1'b0;
              input_pc_ready  <= 1'b1;
              state           <= ST_IDLE;
            end
          end
        end
        ST_OUT2: begin
          if (output_pc_ready) begin
            output_pc_valid <= 1'b0;
            input_pc_ready  <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: begin
          input_pc_ready  <= 1'b1;
          memory_valid    <= 1'b0;
          output_pc_valid <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_basic_block_window.sv
// Scoreboard bench for basic_block_window: expected fetches/outputs queued, monitor pops on handshakes.
module tb_basic_block_window;

  logic        clk;
  logic        reset;
  logic [31:0] current_characters;
  logic        input_pc_valid;
  logic        input_pc_ready;
  logic [7:0]  input_pc;
  logic [1:0]  input_cc_id;
  logic        memory_valid;
  logic        memory_ready;
  logic [10:0] memory_addr;
  logic [15:0] memory_data;
  logic        output_pc_valid;
  logic        output_pc_ready;
  logic [7:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        directed;
  logic        accepts;

  typedef struct packed {
    logic [7:0] pc;
    logic [1:0] cc;
    logic       dir;
  } out_t;

  out_t        exp_out[$];
  logic [10:0] exp_addr[$];
  logic [15:0] imem [0:2047];
  int          checks_total  = 0;
  int          checks_passed = 0;
  int          exp_acc       = 0;
  int          seen_acc      = 0;
  int          stall_cfg     = 0;
  int          stall_cnt     = 0;
  bit          fire_now      = 0;

  basic_block_window dut (
    .clk                              (clk),
    .reset                            (reset),
    .current_characters               (current_characters),
    .input_pc_valid                   (input_pc_valid),
    .input_pc_ready                   (input_pc_ready),
    .input_pc                         (input_pc),
    .input_cc_id                      (input_cc_id),
    .memory_valid                     (memory_valid),
    .memory_ready                     (memory_ready),
    .memory_addr                      (memory_addr),
    .memory_data                      (memory_data),
    .output_pc_valid                  (output_pc_valid),
    .output_pc_ready                  (output_pc_ready),
    .output_pc                        (output_pc),
    .output_cc_id                     (output_cc_id),
    .output_pc_is_directed_to_current (directed),
    .accepts                          (accepts)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Instruction memory: data appears the cycle after a request is accepted.
  always @(posedge clk) begin
    if (memory_valid && memory_ready) memory_data <= imem[memory_addr];
  end

  // Monitor: compares every presented output against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (output_pc_valid) begin
        if (exp_out.size() == 0) begin
          checkOutput("unexpected_output", {22'd0, output_pc, output_cc_id}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_pc", 32'(output_pc), 32'(exp_out[0].pc));
          checkOutput("out_cc_id", 32'(output_cc_id), 32'(exp_out[0].cc));
          checkOutput("out_directed", 32'(directed), 32'(exp_out[0].dir));
          if (output_pc_ready) void'(exp_out.pop_front());
        end
      end
      if (memory_valid && memory_ready) begin
        if (exp_addr.size() == 0) begin
          checkOutput("unexpected_fetch", 32'(memory_addr), 32'hFFFF_FFFF);
        end else begin
          checkOutput("fetch_addr", 32'(memory_addr), 32'(exp_addr[0]));
          void'(exp_addr.pop_front());
        end
      end
      if (accepts) seen_acc++;
    end
  end

  // Downstream ready: optionally held low for stall_cfg cycles per presented output.
  initial begin
    output_pc_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire_now = output_pc_valid && output_pc_ready;
      @(posedge clk);
      #2;
      if (fire_now || !output_pc_valid) stall_cnt = stall_cfg;
      if (output_pc_valid && stall_cnt > 0) begin
        output_pc_ready = 1'b0;
        stall_cnt--;
      end else begin
        output_pc_ready = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] pc, input logic [1:0] cc, input logic [15:0] instr,
                               input int n_out,
                               input logic [7:0] p1, input logic [1:0] c1, input logic d1,
                               input logic [7:0] p2, input logic [1:0] c2, input logic d2,
                               input bit acc);
    int n;
    imem[{3'b000, pc}] = instr;
    exp_addr.push_back({3'b000, pc});
    if (n_out > 0) exp_out.push_back(out_t'{p1, c1, d1});
    if (n_out > 1) exp_out.push_back(out_t'{p2, c2, d2});
    if (acc) exp_acc++;
    @(posedge clk);
    #2;
    input_pc       = pc;
    input_cc_id    = cc;
    input_pc_valid = 1'b1;
    n = 0;
    while (!input_pc_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #2;
    input_pc_valid = 1'b0;
    n = 0;
    while (!input_pc_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("thread_done", 32'(n < 100), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("outputs_drained", 32'(exp_out.size()), 32'd0);
    checkOutput("fetches_drained", 32'(exp_addr.size()), 32'd0);
    checkOutput("accept_count", 32'(seen_acc), 32'(exp_acc));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(input_pc_ready), 32'd1);
    checkOutput({tag, "_mem_valid"}, 32'(memory_valid), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(output_pc_valid), 32'd0);
    checkOutput({tag, "_accepts"}, 32'(accepts), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memory_addr), 32'd0);
    checkOutput({tag, "_out_pc"}, 32'(output_pc), 32'd0);
    checkOutput({tag, "_out_cc"}, 32'(output_cc_id), 32'd0);
    checkOutput({tag, "_directed"}, 32'(directed), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset              = 1'b1;
    current_characters = 32'h3322_11EF;
    input_pc_valid     = 1'b0;
    input_pc           = '0;
    input_cc_id        = '0;
    memory_ready       = 1'b1;
    for (int i = 0; i < 2048; i++) imem[i] = 16'h8000;
    repeat (3) @(posedge clk);
    #2;
    checkResetState("reset");
    reset = 1'b0;

    // Test 1: MATCH EF against slot 0 (EF)
    applyStimulus(8'h12, 2'd0, 16'h40EF, 1, 8'h13, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 0);

    // Test 2: MATCH EE fails, then no output and ready held for 10 cycles
    applyStimulus(8'h12, 2'd0, 16'h40EE, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (output_pc_valid || !input_pc_ready) seen++;
    end
    checkOutput("idle_after_mismatch", 32'(seen), 32'd0);

    // Test 3: SPLIT with downstream stalls; monitor checks stability each stalled cycle
    stall_cfg = 5;
    applyStimulus(8'h05, 2'd3, 16'h2040, 2, 8'h06, 2'd3, 1'b1, 8'h40, 2'd3, 1'b1, 0);
    stall_cfg = 0;

    // Test 4: MATCH_ANY wraps both pc and slot
    applyStimulus(8'hFF, 2'd3, 16'hA000, 1, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);

    // Additional opcodes: JMP, NOT_MATCH both ways, END, MATCH at last slot
    applyStimulus(8'h30, 2'd2, 16'h6077, 1, 8'h77, 2'd2, 1'b1, 8'h00, 2'd0, 1'b0, 0);
    applyStimulus(8'h31, 2'd1, 16'hE011, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);
    applyStimulus(8'h32, 2'd1, 16'hE012, 1, 8'h33, 2'd2, 1'b0, 8'h00, 2'd0, 1'b0, 0);
    applyStimulus(8'h34, 2'd0, 16'h8000, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);
    applyStimulus(8'h35, 2'd3, 16'h4033, 1, 8'h36, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);

    // Test 5: ACCEPT variants with a window holding an end-of-string character in slot 3
    current_characters = 32'h0041_11EF;
    applyStimulus(8'h20, 2'd3, 16'h0000, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1);
    applyStimulus(8'h20, 2'd2, 16'h0000, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 0);
    applyStimulus(8'h21, 2'd1, 16'hC000, 0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1);
    current_characters = 32'h3322_11EF;

    // Test 6a: reset while a fetch is stalled
    memory_ready = 1'b0;
    imem[11'h050] = 16'h40EF;
    @(posedge clk);
    #2;
    input_pc       = 8'h50;
    input_cc_id    = 2'd0;
    input_pc_valid = 1'b1;
    @(posedge clk);
    #2;
    input_pc_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("fetch_pending_mem_valid", 32'(memory_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset        = 1'b0;
    memory_ready = 1'b1;
    checkResetState("reset_in_fetch");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (memory_valid || output_pc_valid) seen++;
    end
    checkOutput("fetch_dropped", 32'(seen), 32'd0);

    // Test 6b: reset while the first SPLIT output is stalled
    stall_cfg = 20;
    imem[11'h005] = 16'h2040;
    exp_addr.push_back(11'h005);
    exp_out.push_back(out_t'{8'h06, 2'd3, 1'b1});
    @(posedge clk);
    #2;
    input_pc       = 8'h05;
    input_cc_id    = 2'd3;
    input_pc_valid = 1'b1;
    @(posedge clk);
    #2;
    input_pc_valid = 1'b0;
    n = 0;
    while (!output_pc_valid && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("split_out1_seen", 32'(output_pc_valid), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_out.delete();
    exp_addr.delete();
    stall_cfg = 0;
    checkResetState("reset_in_out1");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (output_pc_valid) seen++;
    end
    checkOutput("no_out2_after_reset", 32'(seen), 32'd0);

    // Recovery: the first thread runs again cleanly
    applyStimulus(8'h12, 2'd0, 16'h40EF, 1, 8'h13, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
